mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto one shared memory port.
// Round-robin on ties; each transaction runs IDLE -> BUSY_x -> RESP -> IDLE.
module mem_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_be,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0] state;
  logic       last_grant;  // 0 = IF, 1 = D
  logic       grant_d;

  // D wins when it is the only requester, or on a tie when IF was served last.
  always_comb begin
    grant_d = d_req && (!if_req || !last_grant);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the datapath registers are reset as well so
  // the memory port and read-data outputs read as zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
          end else if (if_req) begin
            state     <= BUSY_IF;
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_be    <= 4'hF;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            if_rdata   <= mem_rdata;
            last_grant <= 1'b0;
            state      <= RESP;
          end
        end
        BUSY_D: begin
          // Stores capture too; the requester simply ignores the value.
          if (mem_ready) begin
            d_rdata    <= mem_rdata;
            last_grant <= 1'b1;
            state      <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // last_grant already names the finished requester by the time RESP is reached.
  assign mem_req  = (state == BUSY_IF) || (state == BUSY_D);
  assign if_ready = (state == RESP) && !last_grant;
  assign d_ready  = (state == RESP) && last_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [31:0]   d_wdata, mem_rdata;
  logic [3:0]    d_be;
  logic          mem_ready;
  logic [31:0]   if_rdata, d_rdata, mem_wdata;
  logic          if_ready, d_ready, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;

  int vectors = 0;
  int errors  = 0;

  // Memory responder settings
  int          cnt = 0;
  int          cur_wait = 0;
  int          fixed_wait = 0;
  bit          rand_mem = 1'b0;
  logic [31:0] fixed_rdata = '0;
  logic [31:0] cur_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Advance one cycle, then play the memory for the new cycle: mem_ready rises
  // after cur_wait wait cycles of a request; read data is garbage when idle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_req) begin
      if (cnt == 0) begin
        cur_wait  = rand_mem ? int'($urandom_range(0, 3)) : fixed_wait;
        cur_rdata = rand_mem ? $urandom : fixed_rdata;
      end
      mem_rdata = cur_rdata;
      mem_ready = (cnt == cur_wait);
      cnt++;
    end else begin
      cnt       = 0;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    vectors++;
    if (if_ready && d_ready) begin
      errors++;
      $display("FAIL both_ready: got if_ready=%b d_ready=%b, expected never both high", if_ready, d_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({mem_req, mem_we, if_ready, d_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, mem_we, if_ready, d_ready});
    end
    vectors++;
    if ({mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h be=%h if_rdata=%h d_rdata=%h expected all 0",
               mem_addr, mem_wdata, mem_be, if_rdata, d_rdata);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got mem_req=%b expected 0", mem_req);
    end
  endtask

  task automatic test_if_fetch();
    fixed_wait  = 0;
    fixed_rdata = 32'h0000_0013;
    if_req  = 1'b1;
    if_addr = AW'(32'h100);
    tick();  // cycle 1
    vectors++;
    if ({mem_req, mem_addr, mem_we, mem_be, if_ready} !== {1'b1, AW'(32'h100), 1'b0, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL fetch_cycle1: got req=%b addr=%h we=%b be=%h if_ready=%b expected 1 100 0 f 0",
               mem_req, mem_addr, mem_we, mem_be, if_ready);
    end
    tick();  // cycle 2
    vectors++;
    if ({if_ready, d_ready, mem_req, if_rdata} !== {1'b1, 1'b0, 1'b0, 32'h13}) begin
      errors++;
      $display("FAIL fetch_cycle2: got if_ready=%b d_ready=%b req=%b rdata=%h expected 1 0 0 00000013",
               if_ready, d_ready, mem_req, if_rdata);
    end
    if_req = 1'b0;
    tick();
    vectors++;
    if ({if_ready, mem_req, if_rdata} !== {1'b0, 1'b0, 32'h13}) begin
      errors++;
      $display("FAIL fetch_hold: got if_ready=%b req=%b rdata=%h expected 0 0 00000013",
               if_ready, mem_req, if_rdata);
    end
  endtask

  task automatic test_store();
    int pulses;
    pulses      = 0;
    fixed_wait  = 3;
    fixed_rdata = 32'hA5A5_5A5A;
    d_req   = 1'b1;
    d_addr  = AW'(32'h2000);
    d_we    = 1'b1;
    d_wdata = 32'hDEAD_BEEF;
    d_be    = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(d_ready);
      vectors++;
      if ({mem_req, mem_addr, mem_we, mem_wdata, mem_be} !== {1'b1, AW'(32'h2000), 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin
        errors++;
        $display("FAIL store_stable[%0d]: got req=%b addr=%h we=%b wdata=%h be=%b expected 1 2000 1 deadbeef 0011",
                 i, mem_req, mem_addr, mem_we, mem_wdata, mem_be);
      end
      // Scramble the requester fields, then withdraw the request mid-transaction.
      if (i == 0) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
        d_we    = 1'b0;
      end
      if (i == 1) d_req = 1'b0;
    end
    tick();
    pulses += int'(d_ready);
    vectors++;
    if ({d_ready, if_ready, mem_req, d_rdata} !== {1'b1, 1'b0, 1'b0, 32'hA5A5_5A5A}) begin
      errors++;
      $display("FAIL store_ready: got d_ready=%b if_ready=%b req=%b rdata=%h expected 1 0 0 a5a55a5a",
               d_ready, if_ready, mem_req, d_rdata);
    end
    tick();
    tick();
    pulses += int'(d_ready);
    vectors++;
    if ({pulses, mem_req, d_rdata} !== {32'd1, 1'b0, 32'hA5A5_5A5A}) begin
      errors++;
      $display("FAIL store_once: got pulses=%0d req=%b rdata=%h expected 1 0 a5a55a5a", pulses, mem_req, d_rdata);
    end
  endtask

  task automatic test_addr_stable();
    fixed_wait  = 2;
    fixed_rdata = 32'h1234_5678;
    d_req  = 1'b1;
    d_addr = AW'(32'h40);
    d_we   = 1'b0;
    d_be   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      d_addr = AW'(32'h80);
      vectors++;
      if ({mem_req, mem_addr} !== {1'b1, AW'(32'h40)}) begin
        errors++;
        $display("FAIL addr_stable[%0d]: got req=%b addr=%h expected 1 40", i, mem_req, mem_addr);
      end
    end
    tick();
    vectors++;
    if ({d_ready, d_rdata} !== {1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL addr_ready: got d_ready=%b rdata=%h expected 1 12345678", d_ready, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    rand_mem = 1'b1;
    if_addr  = AW'(32'h1000);
    d_addr   = AW'(32'h2000);
    d_we     = 1'b0;
    d_be     = 4'hF;
    if_req   = 1'b1;
    d_req    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int          n;
      bit          g;
      logic [31:0] got;
      g = k[0];  // IF first, then alternate
      n = 0;
      do begin
        tick();
        n++;
      end while (!mem_req && n < 10);
      vectors++;
      if ({mem_req, mem_addr} !== {1'b1, (g ? AW'(32'h2000) : AW'(32'h1000))}) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got req=%b addr=%h expected 1 %h", k, mem_req, mem_addr,
                 g ? 32'h2000 : 32'h1000);
      end
      n = 0;
      while (!(if_ready || d_ready) && n < 10) begin
        tick();
        n++;
      end
      got = g ? d_rdata : if_rdata;
      vectors++;
      if ({if_ready, d_ready, got} !== {(g ? 2'b01 : 2'b10), cur_rdata}) begin
        errors++;
        $display("FAIL alt_ready[%0d]: got if_ready=%b d_ready=%b rdata=%h expected %b %h", k,
                 if_ready, d_ready, got, g ? 2'b01 : 2'b10, cur_rdata);
      end
    end
    if_req   = 1'b0;
    d_req    = 1'b0;
    rand_mem = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    pulses     = 0;
    fixed_wait = 5;
    if_req  = 1'b1;
    if_addr = AW'(32'h300);
    d_req   = 1'b0;
    tick();
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, AW'(32'h300)}) begin
      errors++;
      $display("FAIL rstmid_busy: got req=%b addr=%h expected 1 300", mem_req, mem_addr);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({mem_req, if_ready, d_ready, mem_addr} !== {3'b000, AW'(0)}) begin
      errors++;
      $display("FAIL rstmid_abort: got req=%b if_ready=%b d_ready=%b addr=%h expected 0 0 0 0",
               mem_req, if_ready, d_ready, mem_addr);
    end
    rst_n  = 1'b1;
    if_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(if_ready) + int'(mem_req);
    end
    vectors++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d ready/req cycles expected 0", pulses);
    end
    if_req  = 1'b1;
    d_req   = 1'b1;
    if_addr = AW'(32'h400);
    d_addr  = AW'(32'h500);
    tick();
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, AW'(32'h400)}) begin
      errors++;
      $display("FAIL rstmid_tie: got req=%b addr=%h expected 1 400", mem_req, mem_addr);
    end
    n = 0;
    while (!(if_ready || d_ready) && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if ({if_ready, d_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_done: got if_ready=%b d_ready=%b expected 1 0", if_ready, d_ready);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    tick();
  endtask

  // Transaction-level model: a new transaction must start exactly one cycle after
  // an idle cycle that saw a request; ties go to whoever was not served last.
  task automatic test_random();
    bit            lg, active, resp_due, in_resp, idle_prev, g, rif, rd, start;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [3:0]    e_be;
    logic [31:0]   e_wdata, e_data;
    lg = 1'b1; active = 1'b0; resp_due = 1'b0; idle_prev = 1'b1; g = 1'b0;
    e_addr = '0; e_we = 1'b0; e_be = '0; e_wdata = '0; e_data = '0;
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    rand_mem = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      rif = if_req;
      rd  = d_req;
      in_resp  = resp_due;
      resp_due = 1'b0;
      vectors++;
      if ({if_ready, d_ready} !== (in_resp ? (g ? 2'b01 : 2'b10) : 2'b00)) begin
        errors++;
        $display("FAIL rnd_ready@%0d: got if_ready=%b d_ready=%b expected %b", c, if_ready, d_ready,
                 in_resp ? (g ? 2'b01 : 2'b10) : 2'b00);
      end
      if (in_resp) begin
        vectors++;
        if ((g ? d_rdata : if_rdata) !== e_data) begin
          errors++;
          $display("FAIL rnd_rdata@%0d: got %h expected %h", c, g ? d_rdata : if_rdata, e_data);
        end
        lg     = g;
        active = 1'b0;
        if (g) d_req = 1'b0;
        else   if_req = 1'b0;
      end
      if (!active) begin
        start = idle_prev && (rif || rd);
        vectors++;
        if (mem_req !== start) begin
          errors++;
          $display("FAIL rnd_start@%0d: got mem_req=%b expected %b", c, mem_req, start);
        end
        if (start) begin
          g       = (rif && rd) ? !lg : rd;
          active  = 1'b1;
          e_addr  = g ? d_addr : if_addr;
          e_we    = g ? d_we : 1'b0;
          e_be    = g ? d_be : 4'hF;
          e_wdata = g ? d_wdata : 32'h0;
        end
      end
      if (active) begin
        vectors++;
        if ({mem_req, mem_addr, mem_we, mem_be, (g ? mem_wdata : 32'h0)} !== {1'b1, e_addr, e_we, e_be, e_wdata}) begin
          errors++;
          $display("FAIL rnd_port@%0d: got req=%b addr=%h we=%b be=%h wdata=%h expected 1 %h %b %h %h",
                   c, mem_req, mem_addr, mem_we, mem_be, mem_wdata, e_addr, e_we, e_be, e_wdata);
        end
        if (mem_ready) begin
          resp_due = 1'b1;
          e_data   = mem_rdata;
        end
      end
      idle_prev = !active && !in_resp;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_addr  = $urandom;
        d_we    = 1'($urandom);
        d_wdata = $urandom;
        d_be    = 4'($urandom);
      end
    end
    rand_mem = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_if_fetch();
    test_store();
    test_addr_stable();
    test_alternate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
